// File: rtl/alu_entry_pkg.sv
// alu_entry_pkg
// Shared types and constants for the ALU operand-entry front-end.
//   entry_state_t  : entry stage encoding; the numeric value is what the
//                    board shows on the stage output
//   OPERAND_WIDTH  : width of each operand taken from the switches
package alu_entry_pkg;

    localparam int OPERAND_WIDTH = 4;

    typedef enum logic [1:0] {
        ENTER_OP1  = 2'd0,
        ENTER_OP2  = 2'd1,
        ENTER_MODE = 2'd2,
        SHOW       = 2'd3
    } entry_state_t;

endpackage

// File: rtl/button_debouncer.sv
// button_debouncer
// Brings one raw, asynchronous push-button into the clk domain and turns
// each accepted press into a single-cycle pulse.
//   clk   : system clock
//   rst   : asynchronous, active-high reset
//   raw   : raw button level, active-high
//   press : one-cycle pulse when the debounced level first reads 1
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    // The edge on which the counter would reach DEBOUNCE_CYCLES is the one
    // that accepts the new level, so compare against one less.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   stable_dly_q;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    // Synchroniser chain, debounce counter, stable level and its delayed copy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q       <= '0;
            cnt_q        <= '0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
        end else begin
            sync_q       <= {sync_q[SYNC_STAGES-2:0], raw};
            cnt_q        <= cnt_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
        end
    end

    // Count consecutive disagreeing cycles; any agreement restarts the count
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (synced != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = synced;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign press = stable_q & ~stable_dly_q;

endmodule

// File: rtl/alu_operand_entry.sv
// alu_operand_entry
// Walks the user through entering operand 1, operand 2 and the ALU mode
// from board switches, using a debounced "next" button to capture each
// value and a debounced "clear" button to start over.
//   clk, rst           : system clock, asynchronous active-high reset
//   sw                 : operand value switches
//   sw_op, sw_sign     : operation select and sign/direction switches
//   btn_next           : raw advance/capture button
//   btn_clear          : raw clear button
//   op1, op2           : captured operands
//   operation, sign    : captured mode bits
//   result_valid       : high while the full set is shown (SHOW)
//   stage              : current entry stage (entry_state_t encoding)
module alu_operand_entry
    import alu_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [OPERAND_WIDTH-1:0] sw,
    input  logic                     sw_op,
    input  logic                     sw_sign,
    input  logic                     btn_next,
    input  logic                     btn_clear,
    output logic [OPERAND_WIDTH-1:0] op1,
    output logic [OPERAND_WIDTH-1:0] op2,
    output logic                     operation,
    output logic                     sign,
    output logic                     result_valid,
    output logic [1:0]               stage
);

    entry_state_t             state_q, state_d;
    logic [OPERAND_WIDTH-1:0] op1_q, op1_d;
    logic [OPERAND_WIDTH-1:0] op2_q, op2_d;
    logic                     operation_q, operation_d;
    logic                     sign_q, sign_d;
    logic                     next_press;
    logic                     clear_press;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_next_btn (
        .clk  (clk),
        .rst  (rst),
        .raw  (btn_next),
        .press(next_press)
    );

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_clear_btn (
        .clk  (clk),
        .rst  (rst),
        .raw  (btn_clear),
        .press(clear_press)
    );

    // State and capture registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ENTER_OP1;
            op1_q       <= '0;
            op2_q       <= '0;
            operation_q <= 1'b0;
            sign_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            operation_q <= operation_d;
            sign_q      <= sign_d;
        end
    end

    // Next state and captures; clear takes priority over next so a
    // simultaneous press never captures anything.
    always_comb begin
        state_d     = state_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        operation_d = operation_q;
        sign_d      = sign_q;
        if (clear_press) begin
            state_d     = ENTER_OP1;
            op1_d       = '0;
            op2_d       = '0;
            operation_d = 1'b0;
            sign_d      = 1'b0;
        end else if (next_press) begin
            case (state_q)
                ENTER_OP1: begin
                    op1_d   = sw;
                    state_d = ENTER_OP2;
                end
                ENTER_OP2: begin
                    op2_d   = sw;
                    state_d = ENTER_MODE;
                end
                ENTER_MODE: begin
                    operation_d = sw_op;
                    sign_d      = sw_sign;
                    state_d     = SHOW;
                end
                SHOW:    state_d = ENTER_OP1;
                default: state_d = ENTER_OP1;
            endcase
        end
    end

    // Outputs come straight from registers
    always_comb begin
        op1          = op1_q;
        op2          = op2_q;
        operation    = operation_q;
        sign         = sign_q;
        result_valid = (state_q == SHOW);
        stage        = state_q;
    end

endmodule

// File: tb/tb_alu_operand_entry.sv
// tb_alu_operand_entry
// Directed bench for alu_operand_entry with DEBOUNCE_CYCLES = 4 and
// SYNC_STAGES = 2. Inputs change on the falling edge and outputs are
// sampled on the falling edge. With those parameters a raw rise just
// before posedge 0 becomes a press after posedge 5 and the FSM reacts
// on posedge 6, i.e. the 7th falling edge after the rise shows the change.
module tb_alu_operand_entry;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sw;
    logic       sw_op;
    logic       sw_sign;
    logic       btn_next;
    logic       btn_clear;
    logic [3:0] op1;
    logic [3:0] op2;
    logic       operation;
    logic       sign;
    logic       result_valid;
    logic [1:0] stage;

    int total = 0;
    int bad   = 0;

    alu_operand_entry #(
        .DEBOUNCE_CYCLES(4),
        .SYNC_STAGES    (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sw          (sw),
        .sw_op       (sw_op),
        .sw_sign     (sw_sign),
        .btn_next    (btn_next),
        .btn_clear   (btn_clear),
        .op1         (op1),
        .op2         (op2),
        .operation   (operation),
        .sign        (sign),
        .result_valid(result_valid),
        .stage       (stage)
    );

    always #5 clk = ~clk;

    // Plain stimulus: hold next for 10 cycles, then release and let the
    // release settle through the debouncer.
    task automatic press_next();
        @(negedge clk);
        btn_next = 1'b1;
        repeat (10) @(negedge clk);
        btn_next = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    // Reset from power-up, then outputs must stay idle with buttons low
    task automatic test_reset();
        rst       = 1'b1;
        sw        = 4'd0;
        sw_op     = 1'b0;
        sw_sign   = 1'b0;
        btn_next  = 1'b0;
        btn_clear = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({op1, op2, operation, sign, result_valid, stage} !== 12'h000) begin
            bad++;
            $display("[TB] FAIL reset_values: got %h expected 000",
                     {op1, op2, operation, sign, result_valid, stage});
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            total++;
            if ({op1, op2, operation, sign, result_valid, stage} !== 12'h000) begin
                bad++;
                $display("[TB] FAIL reset_idle cycle %0d: got %h expected 000", i,
                         {op1, op2, operation, sign, result_valid, stage});
            end
        end
    endtask

    // Three presses walk through OP1, OP2, MODE, checking exact press timing
    task automatic test_full_entry();
        logic [3:0] vals [3];
        vals[0] = 4'd5;
        vals[1] = 4'd3;
        vals[2] = 4'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sw       = vals[i];
            sw_op    = 1'b0;
            sw_sign  = 1'b1;
            btn_next = 1'b1;
            repeat (6) @(negedge clk);
            total++;
            if (stage !== 2'(i)) begin
                bad++;
                $display("[TB] FAIL entry_early step %0d: got stage %0d expected %0d", i, stage, i);
            end
            @(negedge clk);
            total++;
            if (stage !== 2'(i + 1)) begin
                bad++;
                $display("[TB] FAIL entry_on_time step %0d: got stage %0d expected %0d", i, stage, i + 1);
            end
            repeat (3) @(negedge clk);
            btn_next = 1'b0;
            repeat (10) @(negedge clk);
            total++;
            if (stage !== 2'(i + 1)) begin
                bad++;
                $display("[TB] FAIL entry_single_pulse step %0d: got stage %0d expected %0d", i, stage, i + 1);
            end
        end
        total++;
        if ({op1, op2, operation, sign, result_valid, stage} !== {4'd5, 4'd3, 1'b0, 1'b1, 1'b1, 2'd3}) begin
            bad++;
            $display("[TB] FAIL entry_result: got %h expected %h",
                     {op1, op2, operation, sign, result_valid, stage},
                     {4'd5, 4'd3, 1'b0, 1'b1, 1'b1, 2'd3});
        end
    endtask

    // Short bounces on next are ignored; one clean long press advances once
    task automatic test_bounce();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            btn_next = 1'b1;
            repeat (2) @(negedge clk);
            btn_next = 1'b0;
            repeat (1) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        total++;
        if (stage !== 2'd3 || result_valid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL bounce_reject: got stage %0d valid %0b expected 3 1", stage, result_valid);
        end
        @(negedge clk);
        btn_next = 1'b1;
        repeat (8) @(negedge clk);
        btn_next = 1'b0;
        repeat (10) @(negedge clk);
        total++;
        if (stage !== 2'd0 || result_valid !== 1'b0 || op1 !== 4'd5) begin
            bad++;
            $display("[TB] FAIL bounce_accept: got stage %0d valid %0b op1 %0d expected 0 0 5",
                     stage, result_valid, op1);
        end
    endtask

    // Next and clear together in ENTER_MODE: clear wins, nothing captured
    task automatic test_clear_priority();
        sw = 4'd9;
        press_next();
        sw = 4'd2;
        press_next();
        total++;
        if (stage !== 2'd2 || op1 !== 4'd9 || op2 !== 4'd2) begin
            bad++;
            $display("[TB] FAIL clear_setup: got stage %0d op1 %0d op2 %0d expected 2 9 2", stage, op1, op2);
        end
        sw_op   = 1'b1;
        sw_sign = 1'b1;
        @(negedge clk);
        btn_next  = 1'b1;
        btn_clear = 1'b1;
        repeat (10) @(negedge clk);
        btn_next  = 1'b0;
        btn_clear = 1'b0;
        repeat (10) @(negedge clk);
        total++;
        if ({op1, op2, operation, sign, result_valid, stage} !== 12'h000) begin
            bad++;
            $display("[TB] FAIL clear_priority: got %h expected 000",
                     {op1, op2, operation, sign, result_valid, stage});
        end
    endtask

    // Leaving SHOW keeps captured values; idle switch changes are ignored
    task automatic test_wrap();
        sw = 4'd7;
        press_next();
        sw = 4'd1;
        press_next();
        sw_op   = 1'b1;
        sw_sign = 1'b0;
        press_next();
        total++;
        if ({op1, op2, operation, sign, result_valid, stage} !== {4'd7, 4'd1, 1'b1, 1'b0, 1'b1, 2'd3}) begin
            bad++;
            $display("[TB] FAIL wrap_show: got %h expected %h",
                     {op1, op2, operation, sign, result_valid, stage},
                     {4'd7, 4'd1, 1'b1, 1'b0, 1'b1, 2'd3});
        end
        press_next();
        total++;
        if ({op1, op2, operation, sign, result_valid, stage} !== {4'd7, 4'd1, 1'b1, 1'b0, 1'b0, 2'd0}) begin
            bad++;
            $display("[TB] FAIL wrap_leave: got %h expected %h",
                     {op1, op2, operation, sign, result_valid, stage},
                     {4'd7, 4'd1, 1'b1, 1'b0, 1'b0, 2'd0});
        end
        for (int v = 0; v < 16; v++) begin
            @(negedge clk);
            sw      = 4'(v);
            sw_op   = v[0];
            sw_sign = v[1];
        end
        repeat (2) @(negedge clk);
        total++;
        if (op1 !== 4'd7 || op2 !== 4'd1 || stage !== 2'd0) begin
            bad++;
            $display("[TB] FAIL wrap_switch_idle: got op1 %0d op2 %0d stage %0d expected 7 1 0",
                     op1, op2, stage);
        end
    endtask

    // Reset mid-entry with next held: async clear, then one fresh press
    task automatic test_reset_mid();
        sw = 4'hC;
        press_next();
        total++;
        if (stage !== 2'd1 || op1 !== 4'hC) begin
            bad++;
            $display("[TB] FAIL midreset_setup: got stage %0d op1 %0h expected 1 c", stage, op1);
        end
        @(negedge clk);
        btn_next = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({op1, op2, operation, sign, result_valid, stage} !== 12'h000) begin
            bad++;
            $display("[TB] FAIL midreset_async: got %h expected 000",
                     {op1, op2, operation, sign, result_valid, stage});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        total++;
        if (stage !== 2'd0) begin
            bad++;
            $display("[TB] FAIL midreset_early: got stage %0d expected 0", stage);
        end
        @(negedge clk);
        total++;
        if (stage !== 2'd1 || op1 !== 4'hC) begin
            bad++;
            $display("[TB] FAIL midreset_press: got stage %0d op1 %0h expected 1 c", stage, op1);
        end
        btn_next = 1'b0;
        repeat (10) @(negedge clk);
        total++;
        if (stage !== 2'd1) begin
            bad++;
            $display("[TB] FAIL midreset_single: got stage %0d expected 1", stage);
        end
    endtask

    initial begin
        test_reset();
        test_full_entry();
        test_bounce();
        test_clear_priority();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
